// File: rtl/bus_arbiter.sv
// Two-master shared-bus arbiter with round-robin or fixed priority, per-transfer
// wait timeout and an abort state that completes the stalled master with a marker word.
module bus_arbiter #(
  parameter int TIMEOUT     = 1024,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_m0_request,
  input  logic        i_m0_rw,
  input  logic [31:0] i_m0_address,
  input  logic [31:0] i_m0_wdata,
  output logic [31:0] o_m0_rdata,
  output logic        o_m0_ready,
  input  logic        i_m1_request,
  input  logic        i_m1_rw,
  input  logic [31:0] i_m1_address,
  input  logic [31:0] i_m1_wdata,
  output logic [31:0] o_m1_rdata,
  output logic        o_m1_ready,
  output logic        o_bus_request,
  output logic        o_bus_rw,
  output logic [31:0] o_bus_address,
  output logic [31:0] o_bus_wdata,
  input  logic [31:0] i_bus_rdata,
  input  logic        i_bus_ready,
  output logic [1:0]  o_grant,
  output logic        o_timeout
);

  localparam logic [1:0]  IDLE       = 2'd0;
  localparam logic [1:0]  GRANT0     = 2'd1;
  localparam logic [1:0]  GRANT1     = 2'd2;
  localparam logic [1:0]  ABORT      = 2'd3;
  localparam logic [31:0] ABORT_DATA = 32'hDEADBEEF;
  localparam logic [16:0] TIMEOUT_C  = 17'(TIMEOUT);

  logic [1:0]  state_r, next_state_s;
  logic        owner_r, next_owner_s;
  logic        last_r, next_last_s;
  logic [15:0] cnt_r, next_cnt_s;
  logic        timeout_r, next_timeout_s;
  logic [1:0]  grant_r, next_grant_s;
  logic        own_req_s;
  logic        pick_m1_s;
  logic [16:0] cnt_inc_s;

  // Arbitration choice when leaving IDLE; last_r = 1 means m1 was served last
  always_comb begin
    pick_m1_s = 1'b0;
    if (i_m0_request && i_m1_request) begin
      pick_m1_s = ROUND_ROBIN ? ~last_r : 1'b0;
    end else begin
      pick_m1_s = i_m1_request;
    end
  end

  // Next-state, wait counter and timeout pulse decisions
  always_comb begin
    next_state_s   = state_r;
    next_owner_s   = owner_r;
    next_last_s    = last_r;
    next_cnt_s     = cnt_r;
    next_timeout_s = 1'b0;
    own_req_s      = owner_r ? i_m1_request : i_m0_request;
    cnt_inc_s      = {1'b0, cnt_r} + 17'd1;
    case (state_r)
      IDLE: begin
        if (i_m0_request || i_m1_request) begin
          next_state_s = pick_m1_s ? GRANT1 : GRANT0;
          next_owner_s = pick_m1_s;
          next_last_s  = pick_m1_s;
          next_cnt_s   = 16'd0;
        end else begin
          next_state_s = IDLE;
        end
      end
      GRANT0, GRANT1: begin
        if (!own_req_s) begin
          next_state_s = IDLE;
        end else if (!i_bus_ready) begin
          // Completion in the same cycle always beats the abort
          next_cnt_s = cnt_inc_s[15:0];
          if ((TIMEOUT_C != 17'd0) && (cnt_inc_s == TIMEOUT_C)) begin
            next_state_s   = ABORT;
            next_timeout_s = 1'b1;
          end else begin
            next_state_s = state_r;
          end
        end else begin
          next_state_s = state_r;
        end
      end
      ABORT: begin
        if (!own_req_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = ABORT;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Owner indication as it will appear after the coming edge
  always_comb begin
    next_grant_s = 2'b00;
    case (next_state_s)
      GRANT0:  next_grant_s = 2'b01;
      GRANT1:  next_grant_s = 2'b10;
      ABORT:   next_grant_s = next_owner_s ? 2'b10 : 2'b01;
      default: next_grant_s = 2'b00;
    endcase
  end

  // Arbiter registers
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_r   <= IDLE;
      owner_r   <= 1'b0;
      last_r    <= 1'b1;
      cnt_r     <= 16'd0;
      timeout_r <= 1'b0;
      grant_r   <= 2'b00;
    end else begin
      state_r   <= next_state_s;
      owner_r   <= next_owner_s;
      last_r    <= next_last_s;
      cnt_r     <= next_cnt_s;
      timeout_r <= next_timeout_s;
      grant_r   <= next_grant_s;
    end
  end

  // Bus and master return paths steered by the registered state
  always_comb begin
    o_bus_request = 1'b0;
    o_bus_rw      = 1'b0;
    o_bus_address = 32'd0;
    o_bus_wdata   = 32'd0;
    o_m0_rdata    = 32'd0;
    o_m0_ready    = 1'b0;
    o_m1_rdata    = 32'd0;
    o_m1_ready    = 1'b0;
    case (state_r)
      GRANT0: begin
        o_bus_request = i_m0_request;
        o_bus_rw      = i_m0_rw;
        o_bus_address = i_m0_address;
        o_bus_wdata   = i_m0_wdata;
        o_m0_rdata    = i_bus_rdata;
        o_m0_ready    = i_bus_ready;
      end
      GRANT1: begin
        o_bus_request = i_m1_request;
        o_bus_rw      = i_m1_rw;
        o_bus_address = i_m1_address;
        o_bus_wdata   = i_m1_wdata;
        o_m1_rdata    = i_bus_rdata;
        o_m1_ready    = i_bus_ready;
      end
      ABORT: begin
        if (owner_r) begin
          o_m1_rdata = ABORT_DATA;
          o_m1_ready = 1'b1;
        end else begin
          o_m0_rdata = ABORT_DATA;
          o_m0_ready = 1'b1;
        end
      end
      default: begin
        o_bus_request = 1'b0;
      end
    endcase
  end

  assign o_grant   = grant_r;
  assign o_timeout = timeout_r;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: a round-robin and a fixed-priority instance share stimulus,
// both are checked every cycle against a transaction-level model, plus pinned scenarios.
module tb_bus_arbiter;
  localparam int TMO = 8;

  typedef struct packed {
    int owner;    // -1 when nobody holds the bus
    int waited;   // stalled cycles seen in the current tenure
    int last;     // master served most recently
    bit aborted;
    bit pulse;
  } mdl_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        m0_req = 1'b0, m0_rw = 1'b0, m1_req = 1'b0, m1_rw = 1'b0;
  logic [31:0] m0_addr = 32'd0, m0_wdata = 32'd0, m1_addr = 32'd0, m1_wdata = 32'd0;
  logic [31:0] bus_rdata = 32'd0;
  logic        bus_ready = 1'b0;
  logic [31:0] m0_rdata [2], m1_rdata [2], bus_address [2], bus_wdata [2];
  logic        m0_ready [2], m1_ready [2], bus_req [2], bus_rw [2], timeout [2];
  logic [1:0]  grant [2];
  mdl_t        mdl [2];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.TIMEOUT(TMO), .ROUND_ROBIN(1'b1)) dut_rr (
    .i_clock(clk), .i_reset(rst_n),
    .i_m0_request(m0_req), .i_m0_rw(m0_rw), .i_m0_address(m0_addr), .i_m0_wdata(m0_wdata),
    .o_m0_rdata(m0_rdata[0]), .o_m0_ready(m0_ready[0]),
    .i_m1_request(m1_req), .i_m1_rw(m1_rw), .i_m1_address(m1_addr), .i_m1_wdata(m1_wdata),
    .o_m1_rdata(m1_rdata[0]), .o_m1_ready(m1_ready[0]),
    .o_bus_request(bus_req[0]), .o_bus_rw(bus_rw[0]), .o_bus_address(bus_address[0]),
    .o_bus_wdata(bus_wdata[0]), .i_bus_rdata(bus_rdata), .i_bus_ready(bus_ready),
    .o_grant(grant[0]), .o_timeout(timeout[0])
  );

  bus_arbiter #(.TIMEOUT(TMO), .ROUND_ROBIN(1'b0)) dut_fp (
    .i_clock(clk), .i_reset(rst_n),
    .i_m0_request(m0_req), .i_m0_rw(m0_rw), .i_m0_address(m0_addr), .i_m0_wdata(m0_wdata),
    .o_m0_rdata(m0_rdata[1]), .o_m0_ready(m0_ready[1]),
    .i_m1_request(m1_req), .i_m1_rw(m1_rw), .i_m1_address(m1_addr), .i_m1_wdata(m1_wdata),
    .o_m1_rdata(m1_rdata[1]), .o_m1_ready(m1_ready[1]),
    .o_bus_request(bus_req[1]), .o_bus_rw(bus_rw[1]), .o_bus_address(bus_address[1]),
    .o_bus_wdata(bus_wdata[1]), .i_bus_rdata(bus_rdata), .i_bus_ready(bus_ready),
    .o_grant(grant[1]), .o_timeout(timeout[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.owner = -1; r.waited = 0; r.last = 1; r.aborted = 1'b0; r.pulse = 1'b0;
    return r;
  endfunction

  // One bus cycle of the transaction-level view: who owns the bus and how long it has stalled
  function automatic mdl_t mdl_step(mdl_t m, bit rr);
    mdl_t n = m;
    bit own;
    n.pulse = 1'b0;
    if (m.owner < 0) begin
      if (m0_req || m1_req) begin
        if (m0_req && m1_req) n.owner = rr ? 1 - m.last : 0;
        else n.owner = m1_req ? 1 : 0;
        n.last = n.owner; n.waited = 0; n.aborted = 1'b0;
      end
    end else begin
      own = (m.owner == 1) ? m1_req : m0_req;
      if (!own) begin
        n.owner = -1; n.aborted = 1'b0;
      end else if (!m.aborted && !bus_ready) begin
        n.waited = m.waited + 1;
        if (n.waited == TMO) begin
          n.aborted = 1'b1; n.pulse = 1'b1;
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl[0] <= mdl_reset();
      mdl[1] <= mdl_reset();
    end else begin
      mdl[0] <= mdl_step(mdl[0], 1'b1);
      mdl[1] <= mdl_step(mdl[1], 1'b0);
    end
  end

  task automatic compare_one(input int i);
    mdl_t m = mdl[i];
    logic [31:0] e_addr = 32'd0, e_wdata = 32'd0, e_r0 = 32'd0, e_r1 = 32'd0;
    logic e_req = 1'b0, e_rw = 1'b0, e_rd0 = 1'b0, e_rd1 = 1'b0;
    logic [1:0] e_g = 2'b00;
    if (m.owner >= 0) begin
      e_g = (m.owner == 1) ? 2'b10 : 2'b01;
      if (m.aborted) begin
        if (m.owner == 1) begin e_rd1 = 1'b1; e_r1 = 32'hDEADBEEF; end
        else begin e_rd0 = 1'b1; e_r0 = 32'hDEADBEEF; end
      end else if (m.owner == 1) begin
        e_req = m1_req; e_rw = m1_rw; e_addr = m1_addr; e_wdata = m1_wdata;
        e_rd1 = bus_ready; e_r1 = bus_rdata;
      end else begin
        e_req = m0_req; e_rw = m0_rw; e_addr = m0_addr; e_wdata = m0_wdata;
        e_rd0 = bus_ready; e_r0 = bus_rdata;
      end
    end
    check($sformatf("grant[%0d]", i), 32'(grant[i]), 32'(e_g));
    check($sformatf("timeout[%0d]", i), 32'(timeout[i]), 32'(m.pulse));
    check($sformatf("bus_req[%0d]", i), 32'(bus_req[i]), 32'(e_req));
    check($sformatf("bus_rw[%0d]", i), 32'(bus_rw[i]), 32'(e_rw));
    check($sformatf("bus_addr[%0d]", i), bus_address[i], e_addr);
    check($sformatf("bus_wdata[%0d]", i), bus_wdata[i], e_wdata);
    check($sformatf("m0_ready[%0d]", i), 32'(m0_ready[i]), 32'(e_rd0));
    check($sformatf("m0_rdata[%0d]", i), m0_rdata[i], e_r0);
    check($sformatf("m1_ready[%0d]", i), 32'(m1_ready[i]), 32'(e_rd1));
    check($sformatf("m1_rdata[%0d]", i), m1_rdata[i], e_r1);
  endtask

  always @(negedge clk) begin
    #4;
    compare_one(0);
    compare_one(1);
  end

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    logic [1:0] exp_g;
    int rdy_pct = 50;
    #1 rst_n = 1'b0;
    nxt(); nxt(); #3;
    check("rst_grant", 32'(grant[0]), 32'h0);
    check("rst_timeout", 32'(timeout[0]), 32'h0);
    check("rst_busreq", 32'(bus_req[0]), 32'h0);
    nxt(); rst_n = 1'b1;

    // Simultaneous requests: alternate under round-robin, m0 always under fixed priority
    for (int r = 0; r < 4; r++) begin
      nxt(); m0_req = 1'b1; m1_req = 1'b1; m0_addr = 32'h100 + 32'(r); m1_addr = 32'h200 + 32'(r);
      nxt(); #3;
      exp_g = (r % 2 == 0) ? 2'b01 : 2'b10;
      check("rr_order", 32'(grant[0]), 32'(exp_g));
      check("fp_order", 32'(grant[1]), 32'h1);
      bus_ready = 1'b1;
      nxt(); m0_req = 1'b0; m1_req = 1'b0; bus_ready = 1'b0;
      nxt(); #3;
      check("rr_release", 32'(grant[0]), 32'h0);
    end

    // Single m0 read, data returned two cycles after the grant
    nxt(); m0_req = 1'b1; m0_rw = 1'b0; m0_addr = 32'h1000; #3;
    check("rd_idle", 32'(grant[0]), 32'h0);
    nxt(); #3;
    check("rd_grant", 32'(grant[0]), 32'h1);
    check("rd_busreq", 32'(bus_req[0]), 32'h1);
    nxt(); bus_ready = 1'b1; bus_rdata = 32'h12345678; #3;
    check("rd_ready", 32'(m0_ready[0]), 32'h1);
    check("rd_rdata", m0_rdata[0], 32'h12345678);
    nxt(); m0_req = 1'b0; bus_ready = 1'b0; #3;
    check("rd_hold", 32'(grant[0]), 32'h1);
    nxt(); #3;
    check("rd_done", 32'(grant[0]), 32'h0);

    // m1 write: bus carries m1 fields only while m1 owns it
    nxt(); m1_req = 1'b1; m1_rw = 1'b1; m1_addr = 32'h50000010; m1_wdata = 32'hA5; #3;
    check("wr_idle_addr", bus_address[0], 32'h0);
    nxt(); bus_ready = 1'b1; #3;
    check("wr_grant", 32'(grant[0]), 32'h2);
    check("wr_addr", bus_address[0], 32'h50000010);
    check("wr_rw", 32'(bus_rw[0]), 32'h1);
    check("wr_wdata", bus_wdata[0], 32'hA5);
    check("wr_m0_ready", 32'(m0_ready[0]), 32'h0);
    check("wr_m1_ready", 32'(m1_ready[0]), 32'h1);
    nxt(); m1_req = 1'b0; bus_ready = 1'b0;
    nxt(); #3;
    check("wr_after_grant", 32'(grant[0]), 32'h0);
    check("wr_after_addr", bus_address[0], 32'h0);
    check("wr_after_rw", 32'(bus_rw[0]), 32'h0);

    // Stalled read: abort eight cycles after the grant
    nxt(); m0_req = 1'b1; m0_rw = 1'b0; m0_addr = 32'h2000;
    for (int k = 1; k <= 8; k++) begin
      nxt(); #3;
      check("to_wait_pulse", 32'(timeout[0]), 32'h0);
      check("to_wait_grant", 32'(grant[0]), 32'h1);
    end
    nxt(); #3;
    check("to_pulse", 32'(timeout[0]), 32'h1);
    check("to_grant", 32'(grant[0]), 32'h1);
    check("to_ready", 32'(m0_ready[0]), 32'h1);
    check("to_rdata", m0_rdata[0], 32'hDEADBEEF);
    check("to_busreq", 32'(bus_req[0]), 32'h0);
    nxt(); #3;
    check("to_pulse_end", 32'(timeout[0]), 32'h0);
    check("to_ready_hold", 32'(m0_ready[0]), 32'h1);
    m0_req = 1'b0;
    nxt(); #3;
    check("to_idle", 32'(grant[0]), 32'h0);

    // Completion arriving on the deadline cycle wins over the abort
    nxt(); m0_req = 1'b1;
    for (int k = 1; k <= 7; k++) nxt();
    nxt(); bus_ready = 1'b1; bus_rdata = 32'hCAFE0001; #3;
    check("dl_ready", 32'(m0_ready[0]), 32'h1);
    check("dl_rdata", m0_rdata[0], 32'hCAFE0001);
    nxt(); #3;
    check("dl_no_pulse", 32'(timeout[0]), 32'h0);
    check("dl_grant", 32'(grant[0]), 32'h1);
    m0_req = 1'b0; bus_ready = 1'b0;
    nxt();

    // Asynchronous reset in the middle of an m1 transfer
    nxt(); m1_req = 1'b1; m1_rw = 1'b0; m1_addr = 32'h3000; bus_ready = 1'b1; bus_rdata = 32'h77;
    nxt(); #1;
    check("ar_busreq_pre", 32'(bus_req[0]), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("ar_busreq", 32'(bus_req[0]), 32'h0);
    check("ar_grant", 32'(grant[0]), 32'h0);
    check("ar_m1_ready", 32'(m1_ready[0]), 32'h0);
    check("ar_m1_rdata", m1_rdata[0], 32'h0);
    check("ar_addr", bus_address[0], 32'h0);
    nxt(); rst_n = 1'b1;
    nxt(); #3;
    check("ar_regrant", 32'(grant[0]), 32'h2);
    m1_req = 1'b0; bus_ready = 1'b0;
    nxt();

    // Randomised traffic with varying bus stall rates
    for (int c = 0; c < 3000; c++) begin
      nxt();
      if (c % 200 == 0) begin
        case ($urandom_range(0, 2))
          0: rdy_pct = 50;
          1: rdy_pct = 10;
          default: rdy_pct = 0;
        endcase
      end
      if ($urandom_range(0, 5) == 0) begin
        m0_req = ~m0_req;
        m0_rw = 1'($urandom_range(0, 1)); m0_addr = $urandom; m0_wdata = $urandom;
      end
      if ($urandom_range(0, 5) == 0) begin
        m1_req = ~m1_req;
        m1_rw = 1'($urandom_range(0, 1)); m1_addr = $urandom; m1_wdata = $urandom;
      end
      bus_ready = ($urandom_range(0, 99) < rdy_pct);
      bus_rdata = $urandom;
      if (c == 1502) rst_n = 1'b1;
      if (c == 1500) begin
        #2 rst_n = 1'b0;
      end
    end

    nxt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameters SHALL be:
- TIMEOUT, 1024: bus cycles allowed per transfer before abort; 0 disables the timeout.
- ROUND_ROBIN, 1: 1 selects round-robin, 0 selects fixed priority (m0 wins).
REQ-002 Ports SHALL be:
- i_clock  in  1  sole clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset; low = reset.
- i_m0_request  in  1  master 0 request, held until o_m0_ready.
- i_m0_rw  in  1  master 0 direction, 1 = write.
- i_m0_address  in  32  master 0 address.
- i_m0_wdata  in  32  master 0 write data.
- o_m0_rdata  out  32  master 0 read data.
- o_m0_ready  out  1  master 0 completion.
- i_m1_request, i_m1_rw, i_m1_address, i_m1_wdata, o_m1_rdata, o_m1_ready: same widths and meaning for master 1.
- o_bus_request  out  1  shared bus request.
- o_bus_rw  out  1  shared bus direction.
- o_bus_address  out  32  shared bus address.
- o_bus_wdata  out  32  shared bus write data.
- i_bus_rdata  in  32  shared bus read data.
- i_bus_ready  in  1  shared bus completion.
- o_grant  out  2  one-hot owner: bit0 = m0, bit1 = m1, 00 = idle.
- o_timeout  out  1  one-cycle pulse when a transfer is aborted.

Function
REQ-003 The state machine SHALL have four states, IDLE, GRANT0, GRANT1 and ABORT, held in a registered state variable.
REQ-004 In IDLE with any request high, the next state SHALL be GRANT0 or GRANT1 as chosen by REQ-005 and REQ-006; with no request, it SHALL stay in IDLE.
REQ-005 With ROUND_ROBIN=1 and both requests high, the master not served last SHALL win; a last-served register SHALL be updated on each grant.
REQ-006 With ROUND_ROBIN=0 and both requests high, m0 SHALL win.
REQ-007 In GRANTn, o_bus_request/rw/address/wdata SHALL be driven combinationally from master n, o_mn_rdata SHALL equal i_bus_rdata, and o_mn_ready SHALL equal i_bus_ready.
REQ-008 The non-granted master SHALL see ready=0 and rdata=0.
REQ-009 In IDLE and ABORT, o_bus_request SHALL be 0 and bus address/wdata/rw SHALL be 0.
REQ-010 GRANTn SHALL be left for IDLE in the cycle after i_mn_request is sampled low, so the grant is held for the whole master transaction, including consecutive bursts without the request dropping.
REQ-011 Latency SHALL be: request rising at edge k in IDLE gives o_bus_request=1 after edge k+1, and a minimum of 1 idle cycle between consecutive grants.
REQ-012 A 16-bit counter SHALL clear on grant and increment each GRANTn cycle while the granted request is high and i_bus_ready is low.
REQ-013 When the counter reaches TIMEOUT (TIMEOUT≠0), the next state SHALL be ABORT and o_timeout SHALL pulse for 1 cycle.
REQ-014 In ABORT, the owner's ready SHALL be 1 and its rdata SHALL be 32'hDEADBEEF until its request drops, then the state SHALL return to IDLE.
REQ-015 If i_bus_ready and the timeout coincide, completion SHALL win and no abort shall occur.
REQ-016 o_grant SHALL reflect the registered state (GRANT0 = 01, GRANT1 = 10, ABORT = prior owner bit, IDLE = 00).
REQ-017 A request arriving for master n while master n is in ABORT SHALL be ignored until the state has passed through IDLE.

Reset
REQ-018 i_reset low SHALL immediately force IDLE, counter=0, last-served=m1 (so m0 wins first), o_grant=00, o_timeout=0, all ready and bus outputs 0, regardless of any transfer in flight.
REQ-019 Release of i_reset SHALL be synchronised externally; the block SHALL resume arbitration on the first edge with i_reset high.

Verification
REQ-020 Single m0 read: i_bus_ready=1 with rdata 0x12345678 two cycles after grant -> o_m0_ready=1, o_m0_rdata=0x12345678, o_grant 00->01->00.
REQ-021 Simultaneous m0/m1 requests with ROUND_ROBIN=1, repeated 4 times -> grant order m0,m1,m0,m1; with ROUND_ROBIN=0 -> m0 every time while m0 requests.
REQ-022 m1 write to 0x50000010 with wdata 0xA5 -> o_bus_address=0x50000010, o_bus_rw=1, o_bus_wdata=0xA5 only while o_grant=10; m0 sees ready=0 throughout.
REQ-023 TIMEOUT=8, i_bus_ready held 0 -> o_timeout pulses once 8 cycles after grant, o_m0_ready=1 with rdata 0xDEADBEEF, o_bus_request=0 in ABORT.
REQ-024 i_bus_ready=1 on the exact timeout cycle -> normal completion, o_timeout stays 0.
REQ-025 i_reset driven low mid-transfer (o_bus_request=1) -> all outputs 0 without waiting for a clock edge; after release, a held m1 request is granted on the next edge.
